// File: rtl/nios_system_descriptor_fetch.sv
// Walks a linked list of 4-word descriptors over an Avalon-MM read master and
// presents each one on a valid/ready port until end-of-chain or a fault.
module nios_system_descriptor_fetch #(
   parameter int ADDR_W    = 12,
   parameter int MAX_CHAIN = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   output logic [31:0]       desc_next,
   output logic [31:0]       desc_src,
   output logic [31:0]       desc_dst,
   output logic [31:0]       desc_ctrl,
   output logic              desc_valid,
   input  logic              desc_ready,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int CNT_W = $clog2(MAX_CHAIN + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CHAIN);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, CHECK, PRESENT} state_t;

   state_t            state_q;
   logic [1:0]        sync_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] addr_q;
   logic              read_q;
   logic [1:0]        idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       next_q;
   logic [31:0]       src_q;
   logic [31:0]       dst_q;
   logic [31:0]       ctrl_q;
   logic              dvalid_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;

   logic              start_ok_d;
   logic [1:0]        idx_nxt_d;
   logic [ADDR_W-1:0] next_addr_d;
   logic [CNT_W-1:0]  cnt_nxt_d;
   logic              next_bad_d;
   logic              chain_full_d;

   // Reset release is synchronised; start is only honoured once sync_q[1] is set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign start_ok_d   = start && sync_q[1];
   assign idx_nxt_d    = idx_q + 2'd1;
   assign next_addr_d  = base_q + ADDR_W'({idx_nxt_d, 2'b00});
   assign cnt_nxt_d    = cnt_q + CNT_W'(1);
   assign next_bad_d   = (next_q[3:0] != 4'd0) || ((next_q >> ADDR_W) != 32'd0);
   assign chain_full_d = (cnt_nxt_d >= MAX_CNT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         base_q   <= '0;
         addr_q   <= '0;
         read_q   <= 1'b0;
         idx_q    <= 2'd0;
         cnt_q    <= '0;
         next_q   <= 32'd0;
         src_q    <= 32'd0;
         dst_q    <= 32'd0;
         ctrl_q   <= 32'd0;
         dvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_ok_d) begin
                  if (first_addr[3:0] == 4'd0) begin
                     base_q  <= first_addr;
                     addr_q  <= first_addr;
                     read_q  <= 1'b1;
                     idx_q   <= 2'd0;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= ISSUE;
                  end else begin
                     error_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (!avm_waitrequest) begin
                  read_q  <= 1'b0;
                  state_q <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (avm_readdatavalid) begin
                  case (idx_q)
                     2'd0:    next_q <= avm_readdata;
                     2'd1:    src_q  <= avm_readdata;
                     2'd2:    dst_q  <= avm_readdata;
                     default: ctrl_q <= avm_readdata;
                  endcase
                  if (idx_q == 2'd3) begin
                     state_q <= CHECK;
                  end else begin
                     idx_q   <= idx_nxt_d;
                     addr_q  <= next_addr_d;
                     read_q  <= 1'b1;
                     state_q <= ISSUE;
                  end
               end
            end
            CHECK: begin
               // A descriptor not owned by hardware aborts the walk.
               if (!ctrl_q[30]) begin
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  dvalid_q <= 1'b1;
                  state_q  <= PRESENT;
               end
            end
            PRESENT: begin
               if (desc_ready) begin
                  dvalid_q <= 1'b0;
                  cnt_q    <= cnt_nxt_d;
                  if (ctrl_q[31]) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else if (next_bad_d || chain_full_d) begin
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     base_q  <= next_q[ADDR_W-1:0];
                     addr_q  <= next_q[ADDR_W-1:0];
                     idx_q   <= 2'd0;
                     read_q  <= 1'b1;
                     state_q <= ISSUE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign avm_address = addr_q;
   assign avm_read    = read_q;
   assign desc_next   = next_q;
   assign desc_src    = src_q;
   assign desc_dst    = dst_q;
   assign desc_ctrl   = ctrl_q;
   assign desc_valid  = dvalid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule
